// File: rtl/ram_byte_port_pkg.sv
// Shared bus widths, constants and I/O window offsets for the byte-serial memory port.
package ram_byte_port_pkg;

    localparam int unsigned REG_W  = 32;
    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] ZERO8     = 8'h00;
    localparam logic              BIT_TRUE  = 1'b1;
    localparam logic              BIT_FALSE = 1'b0;

    // Offsets from IO_BASE of the output-port data register and the status register.
    localparam logic [REG_W-1:0] IO_TX_OFS   = 32'h0;
    localparam logic [REG_W-1:0] IO_STAT_OFS = 32'h4;

    // Status byte returned by a read of the status register.
    function automatic logic [BYTE_W-1:0] status_byte(input logic full);
        return {7'b0, full};
    endfunction

endpackage

// File: rtl/ram_byte_port_byte_fifo.sv
// Byte FIFO for the output port. Pointers carry one extra wrap bit so full and empty
// are distinguished without a counter. Push on full and pop on empty are ignored.
module byte_fifo
    import ram_byte_port_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              push,
    input  logic [BYTE_W-1:0] din,
    input  logic              pop,
    output logic [BYTE_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PTR_W:0]    wr_ptr_q;
    logic [PTR_W:0]    rd_ptr_q;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    // Full is judged before the pop of the same edge, so a push on full is always rejected.
    assign do_push = en && push && !full;
    assign do_pop  = en && pop && !empty;
    assign dout    = mem[rd_ptr_q[PTR_W-1:0]];

    // Storage: no reset, contents are meaningless once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr_q[PTR_W-1:0]] <= din;
        end
    end

    // Pointer update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/ram_byte_port.sv
// Responder end of the byte-serial memory bus: byte RAM, I/O window decode, output-port
// buffering and one-cycle registered read return.
// Build option: define RAM_BYTE_PORT_IO_FIFO_EN to buffer the output port in a FIFO_DEPTH
// byte FIFO; otherwise a single holding register is used.
module ram_byte_port
    import ram_byte_port_pkg::*;
#(
    parameter int unsigned      ADDR_W     = 17,
    parameter int unsigned      FIFO_DEPTH = 8,
    parameter logic [REG_W-1:0] IO_BASE    = 32'h30000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              ma_ce_in,
    input  logic [REG_W-1:0]  ma_addr_in,
    input  logic [BYTE_W-1:0] ma_data_in,
    input  logic              ma_rw_in,
    output logic [BYTE_W-1:0] ma_data_out,
    output logic              ma_vld_out,
    output logic              ma_busy_out,
    output logic [BYTE_W-1:0] io_tx_data,
    output logic              io_tx_vld,
    input  logic              io_tx_rdy
);

    logic [BYTE_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic              io_sel;
    logic              ram_wr;
    logic              ram_rd;
    logic              io_rd;
    logic              tx_req;
    logic              tx_push;
    logic              tx_pop;
    logic              tx_full;
    logic              tx_empty;
    logic [BYTE_W-1:0] io_rd_byte;

    assign io_sel  = (ma_addr_in >= IO_BASE);
    assign idx     = ma_addr_in[ADDR_W-1:0];
    assign ram_wr  = rdy && ma_ce_in && ma_rw_in && !io_sel;
    assign ram_rd  = rdy && ma_ce_in && !ma_rw_in && !io_sel;
    assign io_rd   = rdy && ma_ce_in && !ma_rw_in && io_sel;
    assign tx_req  = rdy && ma_ce_in && ma_rw_in && (ma_addr_in == IO_BASE + IO_TX_OFS);
    assign tx_push = tx_req && !tx_full;
    assign tx_pop  = rdy && io_tx_vld && io_tx_rdy;

    // Busy only stalls output-port writes that find the buffer full.
    assign ma_busy_out = tx_req && tx_full;
    assign io_tx_vld   = !tx_empty;

    // I/O read result: status register reports full, every other I/O address reads zero.
    always_comb begin
        io_rd_byte = ZERO8;
        if (ma_addr_in == IO_BASE + IO_STAT_OFS) begin
            io_rd_byte = status_byte(tx_full);
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            mem[idx] <= ma_data_in;
        end
    end

    // Registered read return; rdy low freezes both data and valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            ma_data_out <= ZERO8;
            ma_vld_out  <= BIT_FALSE;
        end else if (rdy) begin
            ma_vld_out <= ram_rd || io_rd;
            if (ram_rd) begin
                ma_data_out <= mem[idx];
            end else if (io_rd) begin
                ma_data_out <= io_rd_byte;
            end
        end
    end

`ifdef RAM_BYTE_PORT_IO_FIFO_EN
    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .en    (rdy),
        .push  (tx_push),
        .din   (ma_data_in),
        .pop   (tx_pop),
        .dout  (io_tx_data),
        .empty (tx_empty),
        .full  (tx_full)
    );
`else
    logic [BYTE_W-1:0] hold_q;
    logic              hold_vld_q;

    assign io_tx_data = hold_q;
    assign tx_empty   = !hold_vld_q;
    assign tx_full    = hold_vld_q;

    // Single holding register: a push is only taken when empty, so it never meets a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q     <= ZERO8;
            hold_vld_q <= BIT_FALSE;
        end else if (tx_push) begin
            hold_q     <= ma_data_in;
            hold_vld_q <= BIT_TRUE;
        end else if (tx_pop) begin
            hold_vld_q <= BIT_FALSE;
        end
    end
`endif

endmodule

// File: tb/tb_ram_byte_port.sv
module tb_ram_byte_port;

`ifdef RAM_BYTE_PORT_IO_FIFO_EN
    localparam int DEPTH = 8;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        ma_ce_in;
    logic [31:0] ma_addr_in;
    logic [7:0]  ma_data_in;
    logic        ma_rw_in;
    logic [7:0]  ma_data_out;
    logic        ma_vld_out;
    logic        ma_busy_out;
    logic [7:0]  io_tx_data;
    logic        io_tx_vld;
    logic        io_tx_rdy;

    int checks = 0;
    int errors = 0;

    ram_byte_port dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .ma_ce_in    (ma_ce_in),
        .ma_addr_in  (ma_addr_in),
        .ma_data_in  (ma_data_in),
        .ma_rw_in    (ma_rw_in),
        .ma_data_out (ma_data_out),
        .ma_vld_out  (ma_vld_out),
        .ma_busy_out (ma_busy_out),
        .io_tx_data  (io_tx_data),
        .io_tx_vld   (io_tx_vld),
        .io_tx_rdy   (io_tx_rdy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ce, input logic rw, input logic [31:0] a, input logic [7:0] d);
        ma_ce_in   = ce;
        ma_rw_in   = rw;
        ma_addr_in = a;
        ma_data_in = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; io_tx_rdy = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 8'h00);
        step();
        step();
        rst = 1'b0;
        checks++; if (ma_data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", ma_data_out); end
        checks++; if (ma_vld_out !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", ma_vld_out); end
        checks++; if (io_tx_vld !== 1'b0) begin errors++; $display("FAIL reset_tx_vld got %b want 0", io_tx_vld); end
        checks++; if (ma_busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", ma_busy_out); end
    endtask

    task automatic test_ram_rw();
        drive(1'b1, 1'b1, 32'h10, 8'hA5);
        step();
        checks++; if (ma_vld_out !== 1'b0) begin errors++; $display("FAIL wr_vld got %b want 0", ma_vld_out); end
        drive(1'b1, 1'b0, 32'h10, 8'h00);
        step();
        checks++; if (ma_vld_out !== 1'b1) begin errors++; $display("FAIL rd_vld got %b want 1", ma_vld_out); end
        checks++; if (ma_data_out !== 8'hA5) begin errors++; $display("FAIL rd_data got %h want a5", ma_data_out); end
        drive(1'b0, 1'b0, 32'h10, 8'h00);
        step();
        checks++; if (ma_vld_out !== 1'b0) begin errors++; $display("FAIL idle_vld got %b want 0", ma_vld_out); end
        checks++; if (ma_data_out !== 8'hA5) begin errors++; $display("FAIL idle_hold got %h want a5", ma_data_out); end
    endtask

    task automatic test_alias();
        drive(1'b1, 1'b1, 32'h20010, 8'h11);
        step();
        drive(1'b1, 1'b0, 32'h10, 8'h00);
        step();
        checks++; if (ma_data_out !== 8'h11 || ma_vld_out !== 1'b1) begin
            errors++; $display("FAIL alias got %h/%b want 11/1", ma_data_out, ma_vld_out);
        end
    endtask

    task automatic test_fifo();
        io_tx_rdy = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b1, 1'b1, 32'h30000, 8'(i));
            #1;
            checks++; if (ma_busy_out !== 1'b0) begin errors++; $display("FAIL push_busy[%0d] got %b want 0", i, ma_busy_out); end
            step();
        end
        drive(1'b1, 1'b1, 32'h30000, 8'h77);
        #1;
        checks++; if (ma_busy_out !== 1'b1) begin errors++; $display("FAIL full_busy got %b want 1", ma_busy_out); end
        step();
        drive(1'b1, 1'b1, 32'h30008, 8'h55);
        #1;
        checks++; if (ma_busy_out !== 1'b0) begin errors++; $display("FAIL other_io_busy got %b want 0", ma_busy_out); end
        step();
        drive(1'b1, 1'b0, 32'h30004, 8'h00);
        step();
        checks++; if (ma_data_out !== 8'h01 || ma_vld_out !== 1'b1) begin
            errors++; $display("FAIL stat_full got %h/%b want 01/1", ma_data_out, ma_vld_out);
        end
        drive(1'b1, 1'b0, 32'h30008, 8'h00);
        step();
        checks++; if (ma_data_out !== 8'h00 || ma_vld_out !== 1'b1) begin
            errors++; $display("FAIL other_io_rd got %h/%b want 00/1", ma_data_out, ma_vld_out);
        end
        checks++; if (io_tx_vld !== 1'b1 || io_tx_data !== 8'h01) begin
            errors++; $display("FAIL head got %b/%h want 1/01", io_tx_vld, io_tx_data);
        end
        // Full: push and pop on the same edge, push must still be rejected.
        io_tx_rdy = 1'b1;
        drive(1'b1, 1'b1, 32'h30000, 8'h99);
        #1;
        checks++; if (ma_busy_out !== 1'b1) begin errors++; $display("FAIL pushpop_busy got %b want 1", ma_busy_out); end
        step();
        io_tx_rdy = 1'b0;
        drive(1'b1, 1'b0, 32'h30004, 8'h00);
        step();
        checks++; if (ma_data_out !== 8'h00) begin errors++; $display("FAIL stat_notfull got %h want 00", ma_data_out); end
        drive(1'b0, 1'b0, 32'h0, 8'h00);
        io_tx_rdy = 1'b1;
        for (int v = 2; v <= DEPTH; v++) begin
            checks++; if (io_tx_vld !== 1'b1 || io_tx_data !== 8'(v)) begin
                errors++; $display("FAIL drain[%0d] got %b/%h want 1/%h", v, io_tx_vld, io_tx_data, 8'(v));
            end
            step();
        end
        checks++; if (io_tx_vld !== 1'b0) begin errors++; $display("FAIL drained_vld got %b want 0", io_tx_vld); end
        io_tx_rdy = 1'b0;
    endtask

    task automatic test_rdy_freeze();
        drive(1'b1, 1'b1, 32'h20, 8'h33);
        step();
        drive(1'b1, 1'b0, 32'h10, 8'h00);
        step();
        rdy = 1'b0;
        drive(1'b1, 1'b1, 32'h20, 8'h5A);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ma_busy_out !== 1'b0) begin errors++; $display("FAIL frz_busy[%0d] got %b want 0", i, ma_busy_out); end
            step();
            checks++; if (ma_vld_out !== 1'b1 || ma_data_out !== 8'h11) begin
                errors++; $display("FAIL frz_hold[%0d] got %b/%h want 1/11", i, ma_vld_out, ma_data_out);
            end
        end
        rdy = 1'b1;
        drive(1'b1, 1'b0, 32'h20, 8'h00);
        step();
        checks++; if (ma_data_out !== 8'h33) begin errors++; $display("FAIL frz_ram got %h want 33", ma_data_out); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 32'h30000, 8'hC3);
        step();
        checks++; if (io_tx_vld !== 1'b1) begin errors++; $display("FAIL pre_rst_tx got %b want 1", io_tx_vld); end
        drive(1'b1, 1'b0, 32'h10, 8'h00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 8'h00);
        checks++; if (ma_vld_out !== 1'b0 || ma_data_out !== 8'h00) begin
            errors++; $display("FAIL mid_rst got %b/%h want 0/00", ma_vld_out, ma_data_out);
        end
        checks++; if (io_tx_vld !== 1'b0) begin errors++; $display("FAIL mid_rst_tx got %b want 0", io_tx_vld); end
        drive(1'b1, 1'b0, 32'h30004, 8'h00);
        step();
        checks++; if (ma_data_out !== 8'h00 || ma_vld_out !== 1'b1) begin
            errors++; $display("FAIL post_rst_stat got %h/%b want 00/1", ma_data_out, ma_vld_out);
        end
    endtask

    initial begin
        test_reset();
        test_ram_rw();
        test_alias();
        test_fifo();
        test_rdy_freeze();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
